// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for a single-port synchronous word RAM with 1-cycle read latency.
// M0 (core) has fixed priority; M1 gets a starvation guard and can lock the RAM for itself.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [3:0]            m0_strobe,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [31:0]           m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [3:0]            m1_strobe,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    input  logic                  m1_lock,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [31:0]           m1_rdata,
    output logic                  ram_wr_en,
    output logic [3:0]            ram_wr_strobe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_data_in,
    input  logic [31:0]           ram_data_out,
    output logic [0:0]            dbg_lock_state,
    output logic [7:0]            dbg_wait_cnt
);

    // Handshake: a requester holds req and its command stable until gnt is high in the
    // same cycle; gnt means the access was issued to the RAM that cycle. Read data returns
    // one cycle later, qualified by rvalid. Nothing is buffered inside the arbiter.

    localparam logic [0:0] UNLOCKED = 1'b0;
    localparam logic [0:0] LOCKED   = 1'b1;
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    logic [0:0] lock_state, lock_next;
    logic [7:0] wait_cnt, wait_next;
    logic       m0_rvalid_q, m1_rvalid_q;
    logic       locked;
    logic       sel1;

    assign locked = (lock_state == LOCKED);

    // Grants are forced low during reset so no RAM access escapes while state is clearing.
    assign sel1   = reset_n && m1_req && (locked || !m0_req || (wait_cnt == WAIT_LIMIT));
    assign m1_gnt = sel1;
    assign m0_gnt = reset_n && m0_req && !sel1 && !locked;

    always_comb begin
        ram_wr_en     = 1'b0;
        ram_wr_strobe = 4'b0000;
        ram_addr      = '0;
        ram_data_in   = 32'h0;
        if (m0_gnt) begin
            ram_wr_en     = m0_we;
            ram_wr_strobe = m0_strobe;
            ram_addr      = m0_addr;
            ram_data_in   = m0_wdata;
        end else if (m1_gnt) begin
            ram_wr_en     = m1_we;
            ram_wr_strobe = m1_strobe;
            ram_addr      = m1_addr;
            ram_data_in   = m1_wdata;
        end
    end

    assign m0_rdata  = ram_data_out;
    assign m1_rdata  = ram_data_out;
    // A read issued just before reset asserts is dropped rather than delivered.
    assign m0_rvalid = reset_n && m0_rvalid_q;
    assign m1_rvalid = reset_n && m1_rvalid_q;

    always_comb begin
        wait_next = wait_cnt;
        if (!m1_req || m1_gnt) begin
            wait_next = 8'd0;
        end else if (wait_cnt < WAIT_LIMIT) begin
            wait_next = wait_cnt + 8'd1;
        end
    end

    always_comb begin
        lock_next = lock_state;
        if (lock_state == UNLOCKED) begin
            if (m1_gnt && m1_lock) begin
                lock_next = LOCKED;
            end
        end else begin
            if (!m1_req || (m1_gnt && !m1_lock)) begin
                lock_next = UNLOCKED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lock_state  <= UNLOCKED;
            wait_cnt    <= 8'd0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
        end else begin
            lock_state  <= lock_next;
            wait_cnt    <= wait_next;
            m0_rvalid_q <= m0_gnt && !m0_we;
            m1_rvalid_q <= m1_gnt && !m1_we;
        end
    end

    assign dbg_lock_state = lock_state;
    assign dbg_wait_cnt   = wait_cnt;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed vector table, hand sequences and held random
// requests, all compared against a behavioural model of grants, lock, wait and RAM contents.
module tb_ram_port_arbiter;

    localparam int AW       = 16;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [3:0]    m0_strobe, m1_strobe;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          ram_wr_en;
    logic [3:0]    ram_wr_strobe;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_data_in;
    logic [31:0]   ram_data_out;
    logic [0:0]    dbg_lock_state;
    logic [7:0]    dbg_wait_cnt;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_strobe(m0_strobe), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_strobe(m1_strobe), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .ram_wr_en(ram_wr_en), .ram_wr_strobe(ram_wr_strobe), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .dbg_lock_state(dbg_lock_state), .dbg_wait_cnt(dbg_wait_cnt)
    );

    function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] st);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] seed_word(int i);
        return 32'hA500_0000 ^ (i * 32'h0001_0203);
    endfunction

    // Single-port RAM with one-cycle read latency; filled with seed words while ram_fill is set.
    logic [31:0] ram_mem [0:255];
    logic        ram_fill;
    always @(posedge clk) begin
        if (ram_fill) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= seed_word(i);
        end else begin
            if (ram_wr_en) ram_mem[ram_addr[7:0]] <= merge(ram_mem[ram_addr[7:0]], ram_data_in, ram_wr_strobe);
            ram_data_out <= ram_mem[ram_addr[7:0]];
        end
    end

    // Reference model state
    logic [31:0] exp_mem [0:255];
    bit          m_locked;
    int          m_denied;
    bit          m_rv0, m_rv1;
    logic [7:0]  m_ra0, m_ra1;
    bit          last_g0, last_g1;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge with inputs applied; checks, advances the model, returns at next negedge.
    task automatic step();
        bit e0, e1;
        #2;
        e1 = reset_n && m1_req && (m_locked || !m0_req || m_denied >= MAX_WAIT);
        e0 = reset_n && m0_req && !e1 && !m_locked;
        chk("m0_gnt", m0_gnt, e0);
        chk("m1_gnt", m1_gnt, e1);
        if (e0) begin
            chk("ram_wr_en", ram_wr_en, m0_we);
            chk("ram_wr_strobe", ram_wr_strobe, m0_strobe);
            chk("ram_addr", ram_addr, m0_addr);
            chk("ram_data_in", ram_data_in, m0_wdata);
        end else if (e1) begin
            chk("ram_wr_en", ram_wr_en, m1_we);
            chk("ram_wr_strobe", ram_wr_strobe, m1_strobe);
            chk("ram_addr", ram_addr, m1_addr);
            chk("ram_data_in", ram_data_in, m1_wdata);
        end else begin
            chk("ram_idle", {ram_wr_en, ram_wr_strobe, ram_addr, ram_data_in}, 32'h0);
        end
        chk("m0_rvalid", m0_rvalid, reset_n && m_rv0);
        chk("m1_rvalid", m1_rvalid, reset_n && m_rv1);
        if (reset_n && m_rv0) chk("m0_rdata", m0_rdata, exp_mem[m_ra0]);
        if (reset_n && m_rv1) chk("m1_rdata", m1_rdata, exp_mem[m_ra1]);
        chk("lock_state", dbg_lock_state, m_locked);
        chk("wait_cnt", dbg_wait_cnt, m_denied);
        last_g0 = e0;
        last_g1 = e1;
        if (!reset_n) begin
            m_locked = 0; m_denied = 0; m_rv0 = 0; m_rv1 = 0;
        end else begin
            if (e0 && m0_we) exp_mem[m0_addr[7:0]] = merge(exp_mem[m0_addr[7:0]], m0_wdata, m0_strobe);
            if (e1 && m1_we) exp_mem[m1_addr[7:0]] = merge(exp_mem[m1_addr[7:0]], m1_wdata, m1_strobe);
            m_rv0 = e0 && !m0_we; m_ra0 = m0_addr[7:0];
            m_rv1 = e1 && !m1_we; m_ra1 = m1_addr[7:0];
            // M1 has been kept waiting one more cycle, up to the guard limit.
            if (!m1_req || e1) m_denied = 0;
            else if (m_denied < MAX_WAIT) m_denied++;
            // After an M1 access the RAM stays M1's exactly when it asked; leaving releases it.
            if (e1) m_locked = m1_lock;
            else if (!m1_req) m_locked = 0;
        end
        @(negedge clk);
    endtask

    typedef struct {
        bit          rst;
        bit          m0r, m0w;
        logic [15:0] a0;
        bit          m1r, m1w, lk;
        logic [15:0] a1;
        logic [3:0]  st1;
        logic [31:0] wd1;
        bit          e0, e1, ev0, ev1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit m0r, bit m0w, logic [15:0] a0, bit m1r, bit m1w, bit lk,
                                logic [15:0] a1, logic [3:0] st1, logic [31:0] wd1,
                                bit e0, bit e1, bit ev0, bit ev1);
        vec_t v;
        v.rst = rst; v.m0r = m0r; v.m0w = m0w; v.a0 = a0;
        v.m1r = m1r; v.m1w = m1w; v.lk = lk; v.a1 = a1; v.st1 = st1; v.wd1 = wd1;
        v.e0 = e0; v.e1 = e1; v.ev0 = ev0; v.ev1 = ev1;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; ram_fill = 1'b1;
        m0_req = 0; m0_we = 0; m0_strobe = 4'h0; m0_addr = '0; m0_wdata = 32'h0;
        m1_req = 0; m1_we = 0; m1_strobe = 4'h0; m1_addr = '0; m1_wdata = 32'h0; m1_lock = 0;
        m_locked = 0; m_denied = 0; m_rv0 = 0; m_rv1 = 0; m_ra0 = 8'h0; m_ra1 = 8'h0;
        for (int i = 0; i < 256; i++) exp_mem[i] = seed_word(i);

        // idle reset, M0 read alone, both continuously, M1 byte write, lock hold/release, reset mid-read
        tbl.push_back(mk(1,1,0,16'h0040, 0,0,0,16'h0000,4'h0,32'h0, 1,0,0,0));
        tbl.push_back(mk(1,0,0,16'h0000, 0,0,0,16'h0000,4'h0,32'h0, 0,0,1,0));
        for (int i = 0; i < 2; i++) begin
            tbl.push_back(mk(1,1,0,16'h0041, 1,0,0,16'h0042,4'h0,32'h0, 1,0,0,i));
            tbl.push_back(mk(1,1,0,16'h0041, 1,0,0,16'h0042,4'h0,32'h0, 1,0,1,0));
            tbl.push_back(mk(1,1,0,16'h0041, 1,0,0,16'h0042,4'h0,32'h0, 1,0,1,0));
            tbl.push_back(mk(1,1,0,16'h0041, 1,0,0,16'h0042,4'h0,32'h0, 1,0,1,0));
            tbl.push_back(mk(1,1,0,16'h0041, 1,0,0,16'h0042,4'h0,32'h0, 0,1,1,0));
        end
        tbl.push_back(mk(1,0,0,16'h0000, 0,0,0,16'h0000,4'h0,32'h0, 0,0,0,1));
        tbl.push_back(mk(1,0,0,16'h0000, 1,1,0,16'h0010,4'b0100,32'hAABBCCDD, 0,1,0,0));
        tbl.push_back(mk(1,0,0,16'h0000, 1,0,0,16'h0010,4'h0,32'h0, 0,1,0,0));
        tbl.push_back(mk(1,0,0,16'h0000, 0,0,0,16'h0000,4'h0,32'h0, 0,0,0,1));
        tbl.push_back(mk(1,0,0,16'h0000, 1,0,1,16'h0020,4'h0,32'h0, 0,1,0,0));
        tbl.push_back(mk(1,1,0,16'h0021, 1,0,1,16'h0020,4'h0,32'h0, 0,1,0,1));
        tbl.push_back(mk(1,1,0,16'h0021, 1,0,1,16'h0020,4'h0,32'h0, 0,1,0,1));
        tbl.push_back(mk(1,1,0,16'h0021, 1,0,0,16'h0020,4'h0,32'h0, 0,1,0,1));
        tbl.push_back(mk(1,1,0,16'h0021, 0,0,0,16'h0000,4'h0,32'h0, 1,0,0,1));
        tbl.push_back(mk(1,0,0,16'h0000, 0,0,0,16'h0000,4'h0,32'h0, 0,0,1,0));
        tbl.push_back(mk(1,0,0,16'h0000, 1,0,1,16'h0022,4'h0,32'h0, 0,1,0,0));
        tbl.push_back(mk(1,1,0,16'h0023, 0,0,0,16'h0000,4'h0,32'h0, 0,0,0,1));
        tbl.push_back(mk(1,1,0,16'h0023, 0,0,0,16'h0000,4'h0,32'h0, 1,0,0,0));
        tbl.push_back(mk(1,0,0,16'h0000, 0,0,0,16'h0000,4'h0,32'h0, 0,0,1,0));
        tbl.push_back(mk(1,1,0,16'h0040, 1,0,0,16'h0042,4'h0,32'h0, 1,0,0,0));
        tbl.push_back(mk(0,1,0,16'h0040, 1,0,0,16'h0042,4'h0,32'h0, 0,0,0,0));
        tbl.push_back(mk(1,1,0,16'h0040, 1,0,0,16'h0042,4'h0,32'h0, 1,0,0,0));
        tbl.push_back(mk(1,0,0,16'h0000, 0,0,0,16'h0000,4'h0,32'h0, 0,0,1,0));

        @(negedge clk);
        step();
        step();
        ram_fill = 1'b0;
        reset_n  = 1'b1;

        for (int r = 0; r < tbl.size(); r++) begin
            reset_n = tbl[r].rst;
            m0_req = tbl[r].m0r; m0_we = tbl[r].m0w; m0_addr = tbl[r].a0;
            m0_strobe = 4'hF; m0_wdata = 32'h1234_0000 + r;
            m1_req = tbl[r].m1r; m1_we = tbl[r].m1w; m1_lock = tbl[r].lk; m1_addr = tbl[r].a1;
            m1_strobe = tbl[r].st1; m1_wdata = tbl[r].wd1;
            #1;
            chk($sformatf("row%0d_m0_gnt", r), m0_gnt, tbl[r].e0);
            chk($sformatf("row%0d_m1_gnt", r), m1_gnt, tbl[r].e1);
            chk($sformatf("row%0d_m0_rvalid", r), m0_rvalid, tbl[r].ev0);
            chk($sformatf("row%0d_m1_rvalid", r), m1_rvalid, tbl[r].ev1);
            step();
        end

        // M1 alone, eight back-to-back reads
        for (int i = 0; i < 8; i++) begin
            m0_req = 0; m1_req = 1; m1_we = 0; m1_lock = 0; m1_addr = 16'h0050 + 16'(i);
            #1;
            chk("b2b_m1_gnt", m1_gnt, 1'b1);
            chk("b2b_m1_rvalid", m1_rvalid, i > 0);
            chk("b2b_wait_cnt", dbg_wait_cnt, 8'd0);
            step();
        end
        m1_req = 0;
        #1;
        chk("b2b_last_rvalid", m1_rvalid, 1'b1);
        chk("b2b_last_rdata", m1_rdata, exp_mem[8'h57]);
        step();

        // Random requesters that hold each command until it is granted
        last_g0 = 1; last_g1 = 1;
        for (int n = 0; n < 2000; n++) begin
            if (!m0_req || last_g0) begin
                m0_req = ($urandom_range(0, 3) != 0); m0_we = $urandom_range(0, 1);
                m0_strobe = 4'($urandom_range(0, 15)); m0_addr = 16'($urandom_range(0, 15));
                m0_wdata = $urandom;
            end
            if (!m1_req || last_g1) begin
                m1_req = ($urandom_range(0, 3) != 0); m1_we = $urandom_range(0, 1);
                m1_lock = ($urandom_range(0, 3) == 0);
                m1_strobe = 4'($urandom_range(0, 15)); m1_addr = 16'($urandom_range(0, 15));
                m1_wdata = $urandom;
            end
            reset_n = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
